// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding and default vectors for the fetch PC generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
  localparam int          DEF_INC       = 4;

endpackage

// File: rtl/pc_redir_buf.sv
// pc_redir_buf: holds one captured redirect target and its pending flag.
// Latency: capture/clear take effect on the next rising clk edge.
// Backpressure: none; a new capture overwrites the held target (latest wins).
//
// Ports: clk, rst_n (async active-low), capture, clear, target in;
//        pend, target_q out.
module pc_redir_buf
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic            clear,
  input  logic [XLEN-1:0] target,
  output logic            pend,
  output logic [XLEN-1:0] target_q
);

  logic            pend_q;
  logic            pend_d;
  logic [XLEN-1:0] target_d;

  // Capture beats clear so a redirect arriving on the same edge the old one
  // is consumed is not lost.
  always_comb begin
    pend_d   = pend_q;
    target_d = target_q;
    if (capture) begin
      pend_d   = 1'b1;
      target_d = target;
    end else if (clear) begin
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      target_q <= '0;
    end else begin
      pend_q   <= pend_d;
      target_q <= target_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with boot delay, redirect, trap and halt.
// Latency: every OUT change appears one clk after the causing input is sampled.
// Backpressure: STALL holds OUT; a redirect seen while stalled is parked and
//               applied when the stall releases.
//
// Ports: clk, rst (async active-low), STALL, REDIR_VALID, REDIR_TARGET, TRAP,
//        HALT_REQ, RESUME in; OUT, OUT_VALID, PEND, STATE out.
// Optional: define PC_STALL_CNT_EN to add STALL_CNT[31:0], a saturating count
//           of edges seen in RUN with STALL high.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(DEF_TRAP_VEC),
  parameter int              INC         = DEF_INC,
  parameter int              BOOT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            STALL,
  input  logic            REDIR_VALID,
  input  logic [XLEN-1:0] REDIR_TARGET,
  input  logic            TRAP,
  input  logic            HALT_REQ,
  input  logic            RESUME,
  output logic [XLEN-1:0] OUT,
  output logic            OUT_VALID,
  output logic            PEND,
  output logic [1:0]      STATE
`ifdef PC_STALL_CNT_EN
  ,
  output logic [31:0]     STALL_CNT
`endif
);

  localparam int BC_W = $clog2(BOOT_CYCLES + 1);

  // Word-aligned fetch: drop the byte-offset bits of any redirect/trap target.
  localparam logic [XLEN-1:0] ALIGN_MASK = (INC == 4) ? ~XLEN'(3) : {XLEN{1'b1}};

  pc_state_t       state_q;
  pc_state_t       state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [BC_W-1:0] boot_cnt_q;
  logic [BC_W-1:0] boot_cnt_d;

  logic            buf_capture;
  logic            buf_clear;
  logic            buf_pend;
  logic [XLEN-1:0] buf_target;
  logic [XLEN-1:0] redir_al;
  logic [XLEN-1:0] trap_al;

  assign redir_al = REDIR_TARGET & ALIGN_MASK;
  assign trap_al  = TRAP_VEC & ALIGN_MASK;

  pc_redir_buf #(
    .XLEN (XLEN)
  ) u_redir_buf (
    .clk      (clk),
    .rst_n    (rst),
    .capture  (buf_capture),
    .clear    (buf_clear),
    .target   (redir_al),
    .pend     (buf_pend),
    .target_q (buf_target)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    boot_cnt_d  = boot_cnt_q;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;

    unique case (state_q)
      BOOT: begin
        // PC sits at RESET_VEC and every input is ignored until boot ends.
        if (boot_cnt_q == BC_W'(BOOT_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + BC_W'(1);
        end
      end

      RUN: begin
        if (TRAP) begin
          pc_d      = trap_al;
          buf_clear = 1'b1;
        end else if (HALT_REQ) begin
          state_d     = HALTED;
          buf_capture = REDIR_VALID;
        end else if (REDIR_VALID && !STALL) begin
          // A live redirect supersedes anything parked earlier.
          pc_d      = redir_al;
          buf_clear = 1'b1;
        end else if (REDIR_VALID) begin
          buf_capture = 1'b1;
        end else if (!STALL && buf_pend) begin
          pc_d      = buf_target;
          buf_clear = 1'b1;
        end else if (!STALL) begin
          pc_d = pc_q + XLEN'(INC);
        end
      end

      HALTED: begin
        if (TRAP) begin
          pc_d      = trap_al;
          buf_clear = 1'b1;
        end else begin
          buf_capture = REDIR_VALID;
          // RESUME outranks a simultaneous HALT_REQ; no increment on this edge.
          if (RESUME) begin
            state_d = RUN;
            if (buf_pend) begin
              pc_d      = buf_target;
              buf_clear = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      boot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  assign OUT       = pc_q;
  assign OUT_VALID = (state_q == RUN);
  assign PEND      = buf_pend;
  assign STATE     = state_q;

`ifdef PC_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == RUN) && STALL && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors for pc_gen with a queue-based scoreboard.
// Latency: each vector's expectation is checked 1ns after the following edge.
// Backpressure: n/a.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redir_vld;
  logic [31:0] redir_tgt;
  logic        trap;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc_out;
  logic        out_vld;
  logic        pend;
  logic [1:0]  state;
`ifdef PC_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] out;
    logic        vld;
    logic        pend;
    logic [1:0]  st;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  pc_gen dut (
    .clk          (clk),
    .rst          (rst),
    .STALL        (stall),
    .REDIR_VALID  (redir_vld),
    .REDIR_TARGET (redir_tgt),
    .TRAP         (trap),
    .HALT_REQ     (halt_req),
    .RESUME       (resume),
    .OUT          (pc_out),
    .OUT_VALID    (out_vld),
    .PEND         (pend),
    .STATE        (state)
`ifdef PC_STALL_CNT_EN
    ,
    .STALL_CNT    (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input exp_t e);
    vectors++;
    if (pc_out !== e.out || out_vld !== e.vld || pend !== e.pend || state !== e.st) begin
      miscompares++;
      $display("FAIL %s: got OUT=%h VALID=%b PEND=%b STATE=%0d, want OUT=%h VALID=%b PEND=%b STATE=%0d",
               e.name, pc_out, out_vld, pend, state, e.out, e.vld, e.pend, e.st);
    end
  endtask

  // Monitor: pops one expectation per edge that has one queued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        check(exp_q.pop_front());
      end
    end
  end

  // Drive one cycle of inputs now, queue the state expected after the next edge,
  // then move to the following falling edge.
  task automatic cyc(input logic s, input logic rv, input logic [31:0] tg,
                     input logic tr, input logic h, input logic rs,
                     input logic [31:0] e_out, input logic e_vld,
                     input logic e_pend, input logic [1:0] e_st, input string nm);
    exp_t e;
    stall     = s;
    redir_vld = rv;
    redir_tgt = tg;
    trap      = tr;
    halt_req  = h;
    resume    = rs;
    e.out  = e_out;
    e.vld  = e_vld;
    e.pend = e_pend;
    e.st   = e_st;
    e.name = nm;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  initial begin
    exp_t e;
    rst = 1'b0; stall = 0; redir_vld = 0; redir_tgt = '0; trap = 0; halt_req = 0; resume = 0;
    #2;
    e.out = 32'h0; e.vld = 0; e.pend = 0; e.st = S_BOOT; e.name = "reset_state";
    check(e);
    @(negedge clk);
    rst = 1'b1;

    //   stall rv  target        trap halt res  exp_out        vld pend state
    cyc(0, 0, 32'h0,        1, 0, 0, 32'h0000_0000, 0, 0, S_BOOT, "boot1_trap_ignored");
    cyc(0, 1, 32'h0000_0444, 0, 0, 0, 32'h0000_0000, 1, 0, S_RUN,  "boot2_redir_ignored");
    cyc(0, 0, 32'h0,        0, 0, 0, 32'h0000_0004, 1, 0, S_RUN,  "run_inc4");
    cyc(0, 0, 32'h0,        0, 0, 0, 32'h0000_0008, 1, 0, S_RUN,  "run_inc8");
    cyc(0, 1, 32'h1234_5678, 0, 0, 0, 32'h1234_5678, 1, 0, S_RUN,  "redirect");
    cyc(0, 0, 32'h0,        0, 0, 0, 32'h1234_567C, 1, 0, S_RUN,  "redirect_inc");
    cyc(1, 1, 32'h0000_0040, 0, 0, 0, 32'h1234_567C, 1, 1, S_RUN,  "stall_redir_40");
    cyc(1, 1, 32'h0000_0080, 0, 0, 0, 32'h1234_567C, 1, 1, S_RUN,  "stall_redir_80");
    cyc(1, 0, 32'h0,        0, 0, 0, 32'h1234_567C, 1, 1, S_RUN,  "stall_hold");
    cyc(0, 0, 32'h0,        0, 0, 0, 32'h0000_0080, 1, 0, S_RUN,  "pend_apply_latest");
    cyc(0, 0, 32'h0,        0, 0, 0, 32'h0000_0084, 1, 0, S_RUN,  "after_pend_inc");
    cyc(1, 1, 32'h0000_0200, 0, 0, 0, 32'h0000_0084, 1, 1, S_RUN,  "park_for_trap");
    cyc(1, 1, 32'h0000_0300, 1, 0, 0, 32'h0000_0100, 1, 0, S_RUN,  "trap_precedence");
    cyc(0, 0, 32'h0,        0, 0, 0, 32'h0000_0104, 1, 0, S_RUN,  "after_trap_inc");
    cyc(0, 1, 32'h0000_0020, 0, 0, 0, 32'h0000_0020, 1, 0, S_RUN,  "redir_to_20");
    cyc(0, 0, 32'h0,        0, 1, 0, 32'h0000_0020, 0, 0, S_HALT, "halt");
    cyc(0, 0, 32'h0,        0, 0, 0, 32'h0000_0020, 0, 0, S_HALT, "halted_hold");
    cyc(0, 1, 32'h0F0F_0F0C, 0, 0, 0, 32'h0000_0020, 0, 1, S_HALT, "halted_capture");
    cyc(0, 0, 32'h0,        0, 1, 1, 32'h0F0F_0F0C, 1, 0, S_RUN,  "resume_wins_apply");
    cyc(0, 0, 32'h0,        0, 0, 0, 32'h0F0F_0F10, 1, 0, S_RUN,  "resume_inc");
    cyc(0, 1, 32'h0000_0203, 0, 0, 0, 32'h0000_0200, 1, 0, S_RUN,  "redir_align");
    cyc(0, 0, 32'h0,        0, 1, 0, 32'h0000_0200, 0, 0, S_HALT, "halt2");
    cyc(0, 0, 32'h0,        0, 0, 1, 32'h0000_0200, 1, 0, S_RUN,  "resume_no_inc");
    cyc(0, 0, 32'h0,        0, 0, 0, 32'h0000_0204, 1, 0, S_RUN,  "resume2_inc");
    cyc(0, 1, 32'h0000_0500, 0, 1, 0, 32'h0000_0204, 0, 1, S_HALT, "halt_capture_redir");
    cyc(0, 0, 32'h0,        0, 0, 0, 32'h0000_0204, 0, 1, S_HALT, "halted_keep_pend");
    cyc(0, 0, 32'h0,        1, 0, 0, 32'h0000_0100, 0, 0, S_HALT, "halted_trap");
    cyc(0, 0, 32'h0,        0, 0, 1, 32'h0000_0100, 1, 0, S_RUN,  "resume_after_trap");
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, S_RUN,  "redir_top");
    cyc(0, 0, 32'h0,        0, 0, 0, 32'h0000_0000, 1, 0, S_RUN,  "wrap_to_0");
    cyc(0, 0, 32'h0,        0, 0, 0, 32'h0000_0004, 1, 0, S_RUN,  "post_wrap_inc");
    cyc(1, 1, 32'h0000_0060, 0, 0, 0, 32'h0000_0004, 1, 1, S_RUN,  "park_before_reset");

    // Asynchronous reset mid-cycle: must act before any clock edge.
    stall = 0; redir_vld = 0;
    rst = 1'b0;
    #1;
    e.out = 32'h0; e.vld = 0; e.pend = 0; e.st = S_BOOT; e.name = "async_reset";
    check(e);

    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded 100000 time units, want completion");
    $fatal(1, "timeout");
  end

endmodule
